// File: rtl/dilithium_io_pkg.sv
// rtl/dilithium_io_pkg.sv - shared widths and types for the Dilithium byte ingress path
package dilithium_io_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      word_t data;
      logic  last;
   } fifo_entry_t;

endpackage

// File: rtl/dilithium_word_fifo.sv
// rtl/dilithium_word_fifo.sv - synchronous circular-buffer FIFO of packed words
module dilithium_word_fifo
   import dilithium_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fifo_entry_t              push_entry,
   input  logic                     pop,
   output fifo_entry_t              head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Empty head reads as zero so the word output is clean after reset.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dilithium_byte_packer.sv
// rtl/dilithium_byte_packer.sv - packs framed bytes little-endian into buffered 32-bit words
module dilithium_byte_packer
   import dilithium_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [BYTE_W-1:0]  s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [WORD_W-1:0]  m_data,
   output logic               m_last,
   output logic [15:0]        word_count,
   output logic               busy
);

   localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic              flush;
   word_t             acc;
   word_t             merged;
   logic [1:0]        idx;
   logic              accept;
   logic              complete;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   fifo_entry_t       push_entry;
   fifo_entry_t       head;

   assign flush    = rst || clr;
   assign s_ready  = !fifo_full;
   assign accept   = s_valid && s_ready;
   assign complete = accept && ((idx == LAST_IDX) || s_last);

   // Lanes above idx are already zero in acc, so merging gives the padded word.
   always_comb begin
      merged = acc;
      merged[{idx, 3'b000} +: BYTE_W] = s_data;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         acc <= '0;
         idx <= '0;
      end else if (accept) begin
         if (complete) begin
            acc <= '0;
            idx <= '0;
         end else begin
            acc <= merged;
            idx <= idx + 1'b1;
         end
      end
   end

   assign push_entry = '{data: merged, last: s_last};

   dilithium_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (flush),
      .push       (complete),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   assign m_valid = !fifo_empty;
   assign m_data  = head.data;
   assign m_last  = head.last;
   assign pop     = m_valid && m_ready;
   assign busy    = (idx != 2'd0) || (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (flush) begin
         word_count <= '0;
      end else if (pop) begin
         if (m_last) begin
            word_count <= '0;
         end else if (word_count != 16'hFFFF) begin
            word_count <= word_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/dilithium_byte_packer.md
# dilithium_byte_packer

Byte-to-word ingress stage for the Dilithium core wrapper. Accepts a framed 8-bit byte stream from the host link (UART/DMA bridge) and packs it little-endian into 32-bit words. Output is buffered in a small FIFO and drives the wrapper's `data_i`/`valid_i`/`ready_i` handshake. Partial final words are zero-padded, and a per-frame word count is kept for the host-side status registers.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output word FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset; synchronous, active-high.
- `clr`  in  1  synchronous functional clear. Same effect as `rst` on all state.
- `s_valid`  in  1  byte valid.
- `s_ready`  out  1  byte accepted when `s_valid && s_ready`.
- `s_data`  in  8  byte.
- `s_last`  in  1  marks the final byte of a frame.
- `m_valid`  out  1  word valid; connects to wrapper `valid_i`.
- `m_ready`  in  1  connects from wrapper `ready_i`.
- `m_data`  out  32  packed word; connects to wrapper `data_i`.
- `m_last`  out  1  word holds the frame's last byte.
- `word_count`  out  16  words popped in the current frame.
- `busy`  out  1  partial word pending or FIFO non-empty.

## Operation
- Assembly register `acc[31:0]` and byte index `idx[1:0]`. An accepted byte is written to `acc[8*idx +: 8]`, and `idx` increments.
- Word completes when the accepted byte has `idx == 3` or `s_last == 1`.
  - Completed word = `acc` with the new byte merged in; bytes above `idx` are forced to 0.
  - The word is pushed to the FIFO with `last = s_last`.
  - `acc` is cleared and `idx` returns to 0.
- `s_ready = !fifo_full`. It depends on registered FIFO count only; there is no combinational path from `m_ready`.
- While full, `s_ready` stays low for every byte, even bytes that would not complete a word.
- FIFO: circular buffer, read and write pointers of width log2(`FIFO_DEPTH`) with wrap-around, plus a count of width log2(`FIFO_DEPTH`)+1.
  - `m_valid = (count != 0)`. `m_data` and `m_last` come from the head entry.
  - A push and a pop in the same cycle leave count unchanged and are both legal, including when count == `FIFO_DEPTH` (pop only, since `s_ready` is low) and when count == 0 (push only).
- `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- `word_count` increments on each pop. On a pop with `m_last == 1` it is set to 0 instead. It saturates at 0xFFFF.
- `busy = (idx != 0) || (count != 0)`.
- `clr` or `rst`: FIFO emptied, `acc = 0`, `idx = 0`, `word_count = 0`. Any partial word is discarded with no padding push. A byte presented in the same cycle is dropped.
- Frames need no idle gap. A byte following `s_last` starts a new word at `idx = 0`.

## Timing
- Reset values: `s_ready = 1`, `m_valid = 0`, `m_data = 0`, `m_last = 0`, `word_count = 0`, `busy = 0`.
- Latency: the word whose completing byte is accepted in cycle N is valid on `m_*` in cycle N+1 if the FIFO was empty.
- Throughput: 1 byte/cycle in, up to 1 word/cycle out. Sustained input fills at most 1 word per 4 cycles.
- Full: count reaches `FIFO_DEPTH` in cycle N, so `s_ready = 0` from cycle N+1 until the cycle after the first pop.
- `clr` and `rst` take effect at the next clock edge. Outputs show reset values from the following cycle.

## Structure
- Package `dilithium_io_pkg` holds:
  - constants `BYTE_W = 8`, `WORD_W = 32`, `BYTES_PER_WORD = 4`;
  - typedef `word_t` = `logic [WORD_W-1:0]`;
  - typedef `fifo_entry_t` = struct {`word_t data`; `logic last`}.
- Sub-module `dilithium_word_fifo`: parameterised synchronous FIFO of `fifo_entry_t`, with push, pop, full, empty and count.
- The packer holds the assembly logic and `word_count`.

## Test plan
- Reset, then 8 bytes 0x01..0x08, last on 0x08, `m_ready = 1` → words 0x04030201 (`m_last = 0`) then 0x08070605 (`m_last = 1`); `word_count` goes 1 then 0.
- 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE, last on 0xEE → 0xDDCCBBAA then 0x000000EE with `m_last = 1`.
- `m_ready = 0`, 20 bytes streamed with `FIFO_DEPTH = 4` → `s_ready` drops after the 16th byte and `m_data` holds 0x04030201. Raising `m_ready` drains 4 words in order, then the remaining bytes are accepted. No byte is lost or duplicated.
- Full FIFO with `m_ready = 1` and `s_valid = 1` held → steady state of one push per pop; count never exceeds 4.
- 3 bytes sent, then `clr` pulsed, then 4 bytes 0x11..0x14 with last → single word 0x14131211; no word carries the stale bytes.
- 1-byte frame 0x5A with last, immediately followed by a 4-byte frame → 0x0000005A (last), then the next word starts at byte lane 0.
